// File: rtl/count_monitor_fifo.sv
// Watches a counter value and queues {wrap, count} events for a valid/ready consumer.
// Overflow is tracked by a sticky flag and a saturating drop counter.
module count_monitor_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int DROPW = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] count,
  input  logic             clear_ovf,
  input  logic             ready_in,
  output logic             valid_out,
  output logic [WIDTH-1:0] data_out,
  output logic             wrap_out,
  output logic [AW:0]      level,
  output logic             overflow,
  output logic [DROPW-1:0] drop_count
);

  logic [WIDTH-1:0] prev_count;
  logic [WIDTH-1:0] mem_data [DEPTH];
  logic             mem_wrap [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  logic          ev;
  logic          ev_wrap;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic          bypass;
  logic [AW-1:0] rd_nxt;
  logic [AW:0]   level_nxt;

  // valid_out comes from the registered occupancy only, never from ready_in.
  assign valid_out = (level != '0);

  always_comb begin
    ev        = (count != prev_count);
    ev_wrap   = (count < prev_count);
    full      = (level == (AW+1)'(DEPTH));
    pop       = valid_out & ready_in;
    push      = ev & (~full | pop);
    drop      = ev & full & ~pop;
    rd_nxt    = rd_ptr + AW'(pop);
    level_nxt = level + (AW+1)'(push) - (AW+1)'(pop);
    // New entry lands directly in the head slot when it becomes the head this edge.
    bypass    = push & (wr_ptr == rd_nxt);
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_data[wr_ptr] <= count;
      mem_wrap[wr_ptr] <= ev_wrap;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      data_out   <= '0;
      wrap_out   <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      prev_count <= count;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_nxt;
      level  <= level_nxt;
      // Head registers hold their last value once the FIFO drains.
      if (level_nxt != '0) begin
        data_out <= bypass ? count   : mem_data[rd_nxt];
        wrap_out <= bypass ? ev_wrap : mem_wrap[rd_nxt];
      end
      if (drop) begin
        overflow <= 1'b1;
        if (clear_ovf)                drop_count <= DROPW'(1);
        else if (drop_count != '1)    drop_count <= drop_count + DROPW'(1);
      end else if (clear_ovf) begin
        overflow   <= 1'b0;
        drop_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_count_monitor_fifo.sv
// Directed bench for count_monitor_fifo: expected events are queued as stimulus is
// issued and a negedge monitor pops and compares them whenever the consumer takes one.
module tb_count_monitor_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int DROPW = 8;

  logic             clock;
  logic             reset;
  logic [WIDTH-1:0] count;
  logic             clear_ovf;
  logic             ready_in;
  logic             valid_out;
  logic [WIDTH-1:0] data_out;
  logic             wrap_out;
  logic [AW:0]      level;
  logic             overflow;
  logic [DROPW-1:0] drop_count;

  int checks = 0;
  int errors = 0;
  logic [WIDTH:0] exp_q[$];

  count_monitor_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .DROPW(DROPW)) dut (
    .clock(clock), .reset(reset), .count(count), .clear_ovf(clear_ovf),
    .ready_in(ready_in), .valid_out(valid_out), .data_out(data_out),
    .wrap_out(wrap_out), .level(level), .overflow(overflow), .drop_count(drop_count)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // drivers
  task automatic step(input logic [WIDTH-1:0] c);
    count = c;
    @(posedge clock);
    #1;
  endtask

  task automatic expect_ev(input logic w, input logic [WIDTH-1:0] d);
    exp_q.push_back({w, d});
  endtask

  // scoreboard monitor: a transfer happens at the next posedge when valid&ready here
  always @(negedge clock) begin
    if (reset && valid_out && ready_in) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", {15'd0, wrap_out, data_out}, 32'h1ffff);
      end else begin
        logic [WIDTH:0] e;
        e = exp_q.pop_front();
        chk("pop_data", 32'(data_out), 32'(e[WIDTH-1:0]));
        chk("pop_wrap", 32'(wrap_out), 32'(e[WIDTH]));
      end
    end
  end

  initial begin
    reset = 1'b0; count = '0; clear_ovf = 1'b0; ready_in = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_valid", 32'(valid_out), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_data", 32'(data_out), 0);
    chk("rst_wrap", 32'(wrap_out), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_drop", 32'(drop_count), 0);
    reset = 1'b1;

    // T1 idle
    repeat (20) step(16'd0);
    chk("t1_valid", 32'(valid_out), 0);
    chk("t1_level", 32'(level), 0);
    chk("t1_ovf", 32'(overflow), 0);

    // T2 latency
    expect_ev(1'b0, 16'd1);
    step(16'd1);
    chk("t2_valid", 32'(valid_out), 1);
    chk("t2_data", 32'(data_out), 1);
    chk("t2_wrap", 32'(wrap_out), 0);
    chk("t2_level", 32'(level), 1);
    ready_in = 1'b1;
    step(16'd1);
    chk("t2_empty_valid", 32'(valid_out), 0);
    chk("t2_empty_level", 32'(level), 0);

    // T3 wrap on modulo-8 sequence
    expect_ev(1'b0, 16'd5); step(16'd5);
    expect_ev(1'b0, 16'd6); step(16'd6);
    expect_ev(1'b0, 16'd7); step(16'd7);
    expect_ev(1'b1, 16'd0); step(16'd0);
    expect_ev(1'b0, 16'd1); step(16'd1);
    step(16'd1); step(16'd1);
    chk("t3_level", 32'(level), 0);

    // T4 overflow
    expect_ev(1'b1, 16'd0); step(16'd0);
    step(16'd0); step(16'd0);
    ready_in = 1'b0;
    expect_ev(1'b0, 16'd1); step(16'd1);
    expect_ev(1'b0, 16'd2); step(16'd2);
    expect_ev(1'b0, 16'd3); step(16'd3);
    expect_ev(1'b0, 16'd4); step(16'd4);
    step(16'd5);
    step(16'd6);
    chk("t4_level", 32'(level), 4);
    chk("t4_valid", 32'(valid_out), 1);
    chk("t4_head", 32'(data_out), 1);
    chk("t4_ovf", 32'(overflow), 1);
    chk("t4_drop", 32'(drop_count), 2);

    // T5 full with simultaneous pop and push
    ready_in = 1'b1;
    expect_ev(1'b0, 16'd9); step(16'd9);
    chk("t5_level", 32'(level), 4);
    chk("t5_drop", 32'(drop_count), 2);
    chk("t5_ovf", 32'(overflow), 1);
    repeat (4) step(16'd9);
    chk("t5_level_drained", 32'(level), 0);
    chk("t5_valid_drained", 32'(valid_out), 0);
    chk("t5_data_hold", 32'(data_out), 9);
    chk("t5_wrap_hold", 32'(wrap_out), 0);

    // plain clear
    clear_ovf = 1'b1; step(16'd9); clear_ovf = 1'b0;
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_drop", 32'(drop_count), 0);

    // T6 async reset mid-stream (these entries are discarded, so not expected)
    ready_in = 1'b0;
    step(16'd10); step(16'd11); step(16'd12);
    chk("t6_level3", 32'(level), 3);
    #2 reset = 1'b0;
    #1;
    chk("t6_async_valid", 32'(valid_out), 0);
    chk("t6_async_level", 32'(level), 0);
    count = '0;
    @(posedge clock); #1;
    chk("t6_rst_data", 32'(data_out), 0);
    reset = 1'b1;
    expect_ev(1'b0, 16'd3); step(16'd3);
    chk("t6_first_valid", 32'(valid_out), 1);
    chk("t6_first_data", 32'(data_out), 3);
    chk("t6_first_wrap", 32'(wrap_out), 0);
    expect_ev(1'b0, 16'd4); step(16'd4);
    expect_ev(1'b0, 16'd5); step(16'd5);
    expect_ev(1'b0, 16'd6); step(16'd6);
    step(16'd7);
    step(16'd8);
    chk("t6_drop2", 32'(drop_count), 2);
    clear_ovf = 1'b1; step(16'd9); clear_ovf = 1'b0;
    chk("t6_set_wins_ovf", 32'(overflow), 1);
    chk("t6_set_wins_drop", 32'(drop_count), 1);
    ready_in = 1'b1;
    repeat (6) step(16'd9);
    chk("t6_level_drained", 32'(level), 0);

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
